// File: rtl/bram_march_tester_if.sv
// Memory-side and status bundle of the block-RAM march tester.
// The tester is the master; a memory model or harness takes the slave side.
interface bram_march_tester_if #(
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_ADDRESS_WIDTH = 10,
    parameter int unsigned P_COUNT_WIDTH   = 16
);
    logic                       i_start;
    logic [P_ADDRESS_WIDTH-1:0] o_address_a;
    logic [P_ADDRESS_WIDTH-1:0] o_address_b;
    logic [P_DATA_WIDTH-1:0]    o_data_a;
    logic [P_DATA_WIDTH-1:0]    o_data_b;
    logic                       o_write_enable_a;
    logic                       o_write_enable_b;
    logic [P_DATA_WIDTH-1:0]    i_data_a;
    logic [P_DATA_WIDTH-1:0]    i_data_b;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_pass;
    logic [2:0]                 o_phase;
    logic [P_COUNT_WIDTH-1:0]   o_error_count;
    logic                       o_fail_valid;
    logic [P_ADDRESS_WIDTH-1:0] o_fail_address;
    logic                       o_fail_port_b;
    logic                       o_fail_inverted;

    modport master (
        input  i_start, i_data_a, i_data_b,
        output o_address_a, o_address_b, o_data_a, o_data_b,
               o_write_enable_a, o_write_enable_b,
               o_busy, o_done, o_pass, o_phase, o_error_count,
               o_fail_valid, o_fail_address, o_fail_port_b, o_fail_inverted
    );

    modport slave (
        output i_start, i_data_a, i_data_b,
        input  o_address_a, o_address_b, o_data_a, o_data_b,
               o_write_enable_a, o_write_enable_b,
               o_busy, o_done, o_pass, o_phase, o_error_count,
               o_fail_valid, o_fail_address, o_fail_port_b, o_fail_inverted
    );
endinterface

// File: rtl/bram_march_tester.sv
// Dual-port block-RAM march self-test: fill, verify, invert, verify-inverted.
// Port A walks the low half upward, port B the high half downward.
module bram_march_tester #(
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_ADDRESS_WIDTH = 10,
    parameter int unsigned P_SEED          = 16'h5A5A,
    parameter int unsigned P_COUNT_WIDTH   = 16,
    parameter bit          P_STOP_ON_FAIL  = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    bram_march_tester_if.master bus
);
    localparam int unsigned L_DEPTH = 2 ** P_ADDRESS_WIDTH;
    localparam int unsigned L_HALF  = L_DEPTH / 2;
    localparam int unsigned L_IW    = P_ADDRESS_WIDTH + 1;
    localparam int unsigned L_SUM_W = P_COUNT_WIDTH + 1;

    localparam logic [P_DATA_WIDTH-1:0] L_SEED       = P_DATA_WIDTH'(P_SEED);
    localparam logic [L_IW-1:0]         L_LAST_ISSUE = L_IW'(L_HALF - 1);
    localparam logic [L_IW-1:0]         L_HALF_I     = L_IW'(L_HALF);
    localparam logic [L_IW-1:0]         L_VERIFY_END = L_IW'(L_HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_VERIFY     = 3'd2,
        S_INVERT     = 3'd3,
        S_VERIFY_INV = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    function automatic logic [P_DATA_WIDTH-1:0] f_pat(input logic [P_ADDRESS_WIDTH-1:0] a);
        return P_DATA_WIDTH'(a) ^ L_SEED;
    endfunction

    state_t                     r_state, w_state_next;
    logic [L_IW-1:0]            r_index, w_index_next;

    // Two-stage compare pipeline; port B address is the bitwise complement of port A's.
    logic                       r_s1_valid, r_s1_inv, r_s2_valid, r_s2_inv;
    logic [P_ADDRESS_WIDTH-1:0] r_s1_addr, r_s2_addr;
    logic [P_DATA_WIDTH-1:0]    r_s1_exp_a, r_s1_exp_b, r_s2_exp_a, r_s2_exp_b;

    logic                       w_we, w_issue, w_inv;
    logic [P_ADDRESS_WIDTH-1:0] w_lo, w_addr_a, w_addr_b;
    logic [P_DATA_WIDTH-1:0]    w_data_a, w_data_b, w_exp_a, w_exp_b;
    logic                       w_mis_a, w_mis_b, w_first;
    logic [L_SUM_W-1:0]         w_sum;
    logic [P_COUNT_WIDTH-1:0]   w_count_next;

    assign w_mis_a = r_s2_valid && (bus.i_data_a != r_s2_exp_a);
    assign w_mis_b = r_s2_valid && (bus.i_data_b != r_s2_exp_b);
    assign w_first = (w_mis_a || w_mis_b) && !bus.o_fail_valid;
    assign w_sum   = {1'b0, bus.o_error_count} + L_SUM_W'(w_mis_a) + L_SUM_W'(w_mis_b);
    assign w_count_next = w_sum[P_COUNT_WIDTH] ? {P_COUNT_WIDTH{1'b1}}
                                               : w_sum[P_COUNT_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    // Phase sequencing; verify phases carry drain cycles for the read pipeline.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index + L_IW'(1);
        unique case (r_state)
            S_IDLE: begin
                w_index_next = '0;
                if (bus.i_start) w_state_next = S_FILL;
            end
            S_FILL: if (r_index == L_LAST_ISSUE) begin
                w_state_next = S_VERIFY;
                w_index_next = '0;
            end
            S_VERIFY: if (r_index == L_VERIFY_END) begin
                w_state_next = S_INVERT;
                w_index_next = '0;
            end
            S_INVERT: if (r_index == L_LAST_ISSUE) begin
                w_state_next = S_VERIFY_INV;
                w_index_next = '0;
            end
            S_VERIFY_INV: if (r_index == L_HALF_I) begin
                w_state_next = S_DONE;
                w_index_next = '0;
            end
            S_DONE: begin
                w_index_next = '0;
                if (bus.i_start) w_state_next = S_FILL;
            end
            default: begin
                w_state_next = S_IDLE;
                w_index_next = '0;
            end
        endcase
        if (P_STOP_ON_FAIL && w_first) begin
            w_state_next = S_DONE;
            w_index_next = '0;
        end
    end

    // Memory-side values for the state being entered on this edge.
    always_comb begin
        w_we     = 1'b0;
        w_issue  = 1'b0;
        w_inv    = (w_state_next == S_INVERT) || (w_state_next == S_VERIFY_INV);
        w_lo     = w_index_next[P_ADDRESS_WIDTH-1:0];
        w_addr_a = '0;
        w_addr_b = '0;
        w_data_a = '0;
        w_data_b = '0;
        w_exp_a  = f_pat(w_lo) ^ {P_DATA_WIDTH{w_inv}};
        w_exp_b  = f_pat(~w_lo) ^ {P_DATA_WIDTH{w_inv}};
        unique case (w_state_next)
            S_FILL, S_INVERT: begin
                w_we     = 1'b1;
                w_addr_a = w_lo;
                w_addr_b = ~w_lo;
                w_data_a = w_exp_a;
                w_data_b = w_exp_b;
            end
            S_VERIFY, S_VERIFY_INV: if (w_index_next < L_HALF_I) begin
                w_issue  = 1'b1;
                w_addr_a = w_lo;
                w_addr_b = ~w_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus.o_address_a      <= '0;
            bus.o_address_b      <= '0;
            bus.o_data_a         <= '0;
            bus.o_data_b         <= '0;
            bus.o_write_enable_a <= 1'b0;
            bus.o_write_enable_b <= 1'b0;
            bus.o_busy           <= 1'b0;
            bus.o_done           <= 1'b0;
            bus.o_pass           <= 1'b0;
            bus.o_phase          <= 3'd0;
            bus.o_error_count    <= '0;
            bus.o_fail_valid     <= 1'b0;
            bus.o_fail_address   <= '0;
            bus.o_fail_port_b    <= 1'b0;
            bus.o_fail_inverted  <= 1'b0;
            r_s1_valid           <= 1'b0;
            r_s1_inv             <= 1'b0;
            r_s1_addr            <= '0;
            r_s1_exp_a           <= '0;
            r_s1_exp_b           <= '0;
            r_s2_valid           <= 1'b0;
            r_s2_inv             <= 1'b0;
            r_s2_addr            <= '0;
            r_s2_exp_a           <= '0;
            r_s2_exp_b           <= '0;
        end else begin
            bus.o_address_a      <= w_addr_a;
            bus.o_address_b      <= w_addr_b;
            bus.o_data_a         <= w_data_a;
            bus.o_data_b         <= w_data_b;
            bus.o_write_enable_a <= w_we;
            bus.o_write_enable_b <= w_we;
            bus.o_phase          <= 3'(w_state_next);
            bus.o_busy           <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
            bus.o_done           <= (w_state_next == S_DONE);

            r_s1_valid <= w_issue;
            r_s1_inv   <= w_inv;
            r_s1_addr  <= w_addr_a;
            r_s1_exp_a <= w_exp_a;
            r_s1_exp_b <= w_exp_b;
            r_s2_valid <= r_s1_valid && (w_state_next != S_DONE);
            r_s2_inv   <= r_s1_inv;
            r_s2_addr  <= r_s1_addr;
            r_s2_exp_a <= r_s1_exp_a;
            r_s2_exp_b <= r_s1_exp_b;

            if (r_state == S_DONE && w_state_next == S_FILL) begin
                bus.o_pass          <= 1'b0;
                bus.o_error_count   <= '0;
                bus.o_fail_valid    <= 1'b0;
                bus.o_fail_address  <= '0;
                bus.o_fail_port_b   <= 1'b0;
                bus.o_fail_inverted <= 1'b0;
            end else begin
                if (w_mis_a || w_mis_b) bus.o_error_count <= w_count_next;
                // Port A takes priority when both ports fail on the first failing edge.
                if (w_first) begin
                    bus.o_fail_valid    <= 1'b1;
                    bus.o_fail_address  <= w_mis_a ? r_s2_addr : ~r_s2_addr;
                    bus.o_fail_port_b   <= !w_mis_a;
                    bus.o_fail_inverted <= r_s2_inv;
                end
                if (w_state_next == S_DONE && r_state != S_DONE)
                    bus.o_pass <= (w_count_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_bram_march_tester.sv
// Scoreboarded random bench: three testers (plain, stop-on-fail, 2-bit counter)
// share start and a read-path stuck-at fault, each with its own RAM image.
module tb_bram_march_tester;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned H  = 8;
    localparam int unsigned SEED = 'h5A;

    typedef struct packed {
        logic [15:0]         count;
        logic                pass;
        logic                fv;
        logic [3:0]          faddr;
        logic                fb;
        logic                finv;
        logic [31:0]         lat;
        logic [D-1:0][7:0]   memv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned k = 0;

    logic [1:0] f_port;
    logic [7:0] f_mask;
    logic [7:0] f_set;

    bram_march_tester_if #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_COUNT_WIDTH(16)) bus0 ();
    bram_march_tester_if #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_COUNT_WIDTH(16)) bus1 ();
    bram_march_tester_if #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_COUNT_WIDTH(2))  bus2 ();

    bram_march_tester #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_SEED(SEED),
        .P_COUNT_WIDTH(16), .P_STOP_ON_FAIL(1'b0)) u0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
    bram_march_tester #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_SEED(SEED),
        .P_COUNT_WIDTH(16), .P_STOP_ON_FAIL(1'b1)) u1 (.i_clk(clk), .i_reset(rst), .bus(bus1));
    bram_march_tester #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW), .P_SEED(SEED),
        .P_COUNT_WIDTH(2), .P_STOP_ON_FAIL(1'b0)) u2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

    logic [D-1:0][7:0] mem0, mem1, mem2;
    logic [7:0] rd0a, rd0b, rd1a, rd1b, rd2a, rd2b;

    always @(posedge clk) begin
        if (bus0.o_write_enable_a) mem0[bus0.o_address_a] <= bus0.o_data_a;
        if (bus0.o_write_enable_b) mem0[bus0.o_address_b] <= bus0.o_data_b;
        rd0a <= mem0[bus0.o_address_a];
        rd0b <= mem0[bus0.o_address_b];
    end
    always @(posedge clk) begin
        if (bus1.o_write_enable_a) mem1[bus1.o_address_a] <= bus1.o_data_a;
        if (bus1.o_write_enable_b) mem1[bus1.o_address_b] <= bus1.o_data_b;
        rd1a <= mem1[bus1.o_address_a];
        rd1b <= mem1[bus1.o_address_b];
    end
    always @(posedge clk) begin
        if (bus2.o_write_enable_a) mem2[bus2.o_address_a] <= bus2.o_data_a;
        if (bus2.o_write_enable_b) mem2[bus2.o_address_b] <= bus2.o_data_b;
        rd2a <= mem2[bus2.o_address_a];
        rd2b <= mem2[bus2.o_address_b];
    end

    assign bus0.i_start  = start;
    assign bus1.i_start  = start;
    assign bus2.i_start  = start;
    assign bus0.i_data_a = f_port[0] ? ((rd0a & ~f_mask) | f_set) : rd0a;
    assign bus0.i_data_b = f_port[1] ? ((rd0b & ~f_mask) | f_set) : rd0b;
    assign bus1.i_data_a = f_port[0] ? ((rd1a & ~f_mask) | f_set) : rd1a;
    assign bus1.i_data_b = f_port[1] ? ((rd1b & ~f_mask) | f_set) : rd1b;
    assign bus2.i_data_a = f_port[0] ? ((rd2a & ~f_mask) | f_set) : rd2a;
    assign bus2.i_data_b = f_port[1] ? ((rd2b & ~f_mask) | f_set) : rd2b;

    exp_t q0[$], q1[$], q2[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned a);
        return 8'(a) ^ 8'(SEED);
    endfunction

    // Memory-level view of the march: what each compare sees and when the run ends.
    function automatic exp_t model(input bit stop, input int unsigned cw);
        exp_t e;
        int unsigned maxc = (1 << cw) - 1;
        int unsigned cnt = 0;
        int unsigned addr;
        logic [7:0] img [D];
        logic [7:0] rd;
        bit stopped = 0;
        e = '0;
        e.lat = 32'(2 * D + 3);
        for (int a = 0; a < int'(D); a++) img[a] = pat(a);
        for (int ph = 0; ph < 2 && !stopped; ph++) begin
            if (ph == 1) for (int a = 0; a < int'(D); a++) img[a] = ~pat(a);
            for (int j = 0; j < int'(H) && !stopped; j++) begin
                for (int p = 0; p < 2; p++) begin
                    addr = (p == 0) ? j : D - 1 - j;
                    rd = img[addr];
                    if (f_port[p]) rd = (rd & ~f_mask) | f_set;
                    if (rd != img[addr]) begin
                        cnt = (cnt + 1 > maxc) ? maxc : cnt + 1;
                        if (!e.fv) begin
                            e.fv = 1'b1;
                            e.faddr = 4'(addr);
                            e.fb = (p == 1);
                            e.finv = (ph == 1);
                            if (stop) begin
                                stopped = 1;
                                e.lat = 32'(((ph == 0) ? H : 3 * H + 2) + j + 2);
                            end
                        end
                    end
                end
            end
        end
        e.count = 16'(cnt);
        e.pass = (cnt == 0);
        for (int a = 0; a < int'(D); a++) e.memv[a] = img[a];
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e, input logic [15:0] cnt,
                                input logic pass, input logic fv, input logic [3:0] fa,
                                input logic fb, input logic fi, input logic bus_idle,
                                input logic [127:0] mv);
        chk({tag, " done_edge"}, 128'(cyc), 128'(e.lat));
        chk({tag, " error_count"}, 128'(cnt), 128'(e.count));
        chk({tag, " pass"}, 128'(pass), 128'(e.pass));
        chk({tag, " fail_valid"}, 128'(fv), 128'(e.fv));
        chk({tag, " fail_where"}, 128'({fa, fb, fi}), 128'({e.faddr, e.fb, e.finv}));
        chk({tag, " bus_idle"}, 128'(bus_idle), 128'(1));
        chk({tag, " ram_image"}, mv, 128'(e.memv));
    endtask

    // Monitor: each rising O_DONE pops and checks that tester's expected result.
    logic p0 = 0, p1 = 0, p2 = 0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus0.o_done && !p0) begin
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u0 spurious_done: got done, expected no pending run");
                end else
                    check_result("u0", q0.pop_front(), bus0.o_error_count, bus0.o_pass,
                        bus0.o_fail_valid, bus0.o_fail_address, bus0.o_fail_port_b,
                        bus0.o_fail_inverted,
                        !(bus0.o_write_enable_a | bus0.o_write_enable_b | (|bus0.o_address_a)
                          | (|bus0.o_address_b) | (|bus0.o_data_a) | (|bus0.o_data_b)), mem0);
            end
            if (bus1.o_done && !p1) begin
                if (q1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u1 spurious_done: got done, expected no pending run");
                end else
                    check_result("u1", q1.pop_front(), bus1.o_error_count, bus1.o_pass,
                        bus1.o_fail_valid, bus1.o_fail_address, bus1.o_fail_port_b,
                        bus1.o_fail_inverted,
                        !(bus1.o_write_enable_a | bus1.o_write_enable_b | (|bus1.o_address_a)
                          | (|bus1.o_address_b) | (|bus1.o_data_a) | (|bus1.o_data_b)), mem1);
            end
            if (bus2.o_done && !p2) begin
                if (q2.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL u2 spurious_done: got done, expected no pending run");
                end else
                    check_result("u2", q2.pop_front(), 16'(bus2.o_error_count), bus2.o_pass,
                        bus2.o_fail_valid, bus2.o_fail_address, bus2.o_fail_port_b,
                        bus2.o_fail_inverted,
                        !(bus2.o_write_enable_a | bus2.o_write_enable_b | (|bus2.o_address_a)
                          | (|bus2.o_address_b) | (|bus2.o_data_a) | (|bus2.o_data_b)), mem2);
            end
            p0 = bus0.o_done;
            p1 = bus1.o_done;
            p2 = bus2.o_done;
        end
    end

    task automatic outs_zero(input string nm);
        chk({nm, " u0 outputs"}, 128'({bus0.o_address_a, bus0.o_address_b, bus0.o_data_a,
            bus0.o_data_b, bus0.o_write_enable_a, bus0.o_write_enable_b, bus0.o_busy,
            bus0.o_done, bus0.o_pass, bus0.o_phase, bus0.o_error_count, bus0.o_fail_valid,
            bus0.o_fail_address, bus0.o_fail_port_b, bus0.o_fail_inverted}), 128'(0));
        chk({nm, " u1 outputs"}, 128'({bus1.o_address_a, bus1.o_address_b, bus1.o_data_a,
            bus1.o_data_b, bus1.o_write_enable_a, bus1.o_write_enable_b, bus1.o_busy,
            bus1.o_done, bus1.o_pass, bus1.o_phase, bus1.o_error_count, bus1.o_fail_valid,
            bus1.o_fail_address, bus1.o_fail_port_b, bus1.o_fail_inverted}), 128'(0));
        chk({nm, " u2 outputs"}, 128'({bus2.o_address_a, bus2.o_address_b, bus2.o_data_a,
            bus2.o_data_b, bus2.o_write_enable_a, bus2.o_write_enable_b, bus2.o_busy,
            bus2.o_done, bus2.o_pass, bus2.o_phase, bus2.o_error_count, bus2.o_fail_valid,
            bus2.o_fail_address, bus2.o_fail_port_b, bus2.o_fail_inverted}), 128'(0));
    endtask

    function automatic logic [2:0] exp_phase(input int unsigned off);
        if (off < H)             return 3'd1;
        if (off < D + 2)         return 3'd2;
        if (off < 3 * H + 2)     return 3'd3;
        if (off < 2 * D + 3)     return 3'd4;
        return 3'd5;
    endfunction

    task automatic set_fault(input logic [1:0] port, input int unsigned bitn, input logic val);
        f_port = port;
        f_mask = 8'(1) << bitn;
        f_set  = val ? f_mask : 8'h00;
    endtask

    // Starts a run, queues expectations, pulses START once mid-FILL if asked.
    task automatic run(input bit busy_pulse);
        exp_t e;
        int unsigned off;
        int unsigned bp = $urandom_range(1, H - 2);
        int bad = 0;
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        e = model(1'b0, 16); e.lat = e.lat + k; q0.push_back(e);
        e = model(1'b1, 16); e.lat = e.lat + k; q1.push_back(e);
        e = model(1'b0, 2);  e.lat = e.lat + k; q2.push_back(e);
        for (int c = 0; c < int'(2 * D + 8); c++) begin
            @(negedge clk);
            off = cyc - k;
            start = busy_pulse && (off == bp);
            if (off == 0) begin
                chk("restart clears u0", 128'({bus0.o_done, bus0.o_pass, bus0.o_error_count,
                    bus0.o_fail_valid, bus0.o_busy}), 128'(1));
                chk("restart clears u1", 128'({bus1.o_done, bus1.o_pass, bus1.o_error_count,
                    bus1.o_fail_valid, bus1.o_busy}), 128'(1));
            end
            if (bus0.o_phase != exp_phase(off)) bad++;
            if (bus0.o_busy != (exp_phase(off) != 3'd5)) bad++;
            if (bus1.o_done && (bus1.o_write_enable_a || bus1.o_write_enable_b)) bad++;
        end
        chk("u0 phase/busy timeline", 128'(bad), 128'(0));
        chk("all runs completed", 128'(q0.size() + q1.size() + q2.size()), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_fault(2'b00, 0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        outs_zero("reset");
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle after reset", 128'({bus0.o_phase, bus0.o_busy, bus0.o_done}), 128'(0));

        run(1'b0);                               // clean run
        set_fault(2'b10, 0, 1'b1);               // port B bit0 stuck-at-1
        run(1'b1);
        run(1'b0);                               // restart from DONE repeats identically

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #2 rst = 1'b1;
        #1 outs_zero("reset mid-fill");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_fault(2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            run(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
